alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 23 ++
 rtl/alu_mul_seq.sv | 50 +++++
 rtl/alu_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode and FSM state encodings for the ALU sequencer, its MUL
// datapath and any bench that drives it.
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one multiplier bit per cycle, DATA_W cycles per product,
// double-width accumulator.
module alu_mul_seq #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [2*DATA_W-1:0] acc_q, acc_d, mcand_q, addend;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                run_q;

    assign addend = mplier_q[0] ? mcand_q : '0;
    assign acc_d  = acc_q + addend;

    // Done flags the final step so the caller can take acc_d on the same edge.
    assign done_o    = run_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: accepts one instruction, reads two registers,
// executes (1 cycle, or DATA_W cycles for MUL) and writes the result back.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instrValid,
    output logic              instrReady,
    input  logic [2:0]        instrOp,
    input  logic [ADDR_W-1:0] instrRd,
    input  logic [ADDR_W-1:0] instrRs1,
    input  logic [ADDR_W-1:0] instrRs2,
    output logic [ADDR_W-1:0] regOut1Addr,
    output logic [ADDR_W-1:0] regOut2Addr,
    input  logic [DATA_W-1:0] regOut1,
    input  logic [DATA_W-1:0] regOut2,
    output logic [DATA_W-1:0] regIn,
    output logic [ADDR_W-1:0] regInAddr,
    output logic              regInWE,
    output logic              busy,
    output logic              done,
    output logic              flagZ,
    output logic              flagC
);
    state_e              state_q;
    op_e                 op_q;
    logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q, wb_addr_q;
    logic [DATA_W-1:0]   a_q, b_q, wb_data_q;
    logic                we_q, done_q, busy_q, z_q, c_q;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                mul_start, mul_done;
    logic [2*DATA_W-1:0] mul_prod;

    assign instrReady  = (state_q == ST_IDLE);
    assign regOut1Addr = rs1_q;
    assign regOut2Addr = rs2_q;
    assign regIn       = wb_data_q;
    assign regInAddr   = wb_addr_q;
    assign regInWE     = we_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign flagZ       = z_q;
    assign flagC       = c_q;

    // The multiplier captures the register-file data directly at the end of FETCH.
    assign mul_start = (state_q == ST_FETCH) && (op_q == OP_MUL);

    alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (regOut1),
        .b_i       (regOut2),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: {alu_c, alu_res} = {a_q, 1'b0};
            OP_SHR: {alu_res, alu_c} = {1'b0, a_q};
            OP_MUL: begin
                alu_res = mul_prod[DATA_W-1:0];
                alu_c   = |mul_prod[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (instrValid) begin
                    op_q    <= op_e'(instrOp);
                    rd_q    <= instrRd;
                    rs1_q   <= instrRs1;
                    rs2_q   <= instrRs2;
                    busy_q  <= 1'b1;
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    a_q     <= regOut1;
                    b_q     <= regOut2;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: if (op_q != OP_MUL || mul_done) begin
                    wb_data_q <= alu_res;
                    wb_addr_q <= rd_q;
                    we_q      <= 1'b1;
                    done_q    <= 1'b1;
                    z_q       <= (alu_res == '0);
                    c_q       <= alu_c;
                    state_q   <= ST_WB;
                end
                ST_WB: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: alu_sequencer paired with an 8x16 register file, table of
// instructions plus back-to-back and mid-MUL reset sequences.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, load = 1'b1;
    logic        instrValid = 1'b0, instrReady;
    logic [2:0]  instrOp = '0, instrRd = '0, instrRs1 = '0, instrRs2 = '0;
    logic [2:0]  regOut1Addr, regOut2Addr, regInAddr;
    logic [15:0] regOut1, regOut2, regIn;
    logic        regInWE, busy, done, flagZ, flagC;
    logic [15:0] rf [8];

    int checks = 0, passed = 0;

    alu_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .instrValid(instrValid), .instrReady(instrReady),
        .instrOp(instrOp), .instrRd(instrRd), .instrRs1(instrRs1), .instrRs2(instrRs2),
        .regOut1Addr(regOut1Addr), .regOut2Addr(regOut2Addr),
        .regOut1(regOut1), .regOut2(regOut2), .regIn(regIn), .regInAddr(regInAddr),
        .regInWE(regInWE), .busy(busy), .done(done), .flagZ(flagZ), .flagC(flagC)
    );

    always #5 clk = ~clk;

    assign regOut1 = rf[regOut1Addr];
    assign regOut2 = rf[regOut2Addr];

    always @(posedge clk) begin
        if (load) begin
            rf[0] <= 16'h0000; rf[1] <= 16'h0003; rf[2] <= 16'h0005; rf[3] <= 16'hFFFF;
            rf[4] <= 16'h8001; rf[5] <= 16'h0000; rf[6] <= 16'h0000; rf[7] <= 16'h0000;
        end else if (regInWE) begin
            rf[regInAddr] <= regIn;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0]  op, rd, rs1, rs2;
        logic [15:0] res;
        logic        z, c;
        int          lat;
    } vec_t;

    vec_t vt[11];

    // Offer one instruction, measure accept-to-WB latency, then check write and flags.
    task automatic run_vec(input vec_t v);
        int w, n;
        @(negedge clk);
        instrValid = 1'b1; instrOp = v.op; instrRd = v.rd; instrRs1 = v.rs1; instrRs2 = v.rs2;
        w = 0;
        while (!instrReady && w < 50) begin @(negedge clk); w++; end
        if (!instrReady) begin chk("ready_timeout", 0, 1); instrValid = 1'b0; return; end
        n = 0;
        do begin
            @(negedge clk);
            instrValid = 1'b0;
            n++;
        end while (!regInWE && n < 40);
        chk("wb_latency", n, v.lat);
        chk("wb_addr", regInAddr, v.rd);
        chk("wb_data", regIn, v.res);
        chk("done_with_we", done, 1);
        chk("busy_in_wb", busy, 1);
        @(negedge clk);
        chk("rf_written", rf[v.rd], v.res);
        chk("flagZ", flagZ, v.z);
        chk("flagC", flagC, v.c);
        chk("we_one_cycle", regInWE, 0);
        chk("ready_after_wb", instrReady, 1);
    endtask

    logic [2:0]  rds   [4];
    logic [2:0]  waddr [4];
    logic [15:0] wdata [4];
    int          wcyc  [4];

    initial begin
        int issued, nw, n, extra;

        vt[0]  = '{OP_ADD, 3'd6, 3'd3, 3'd1, 16'h0002, 1'b0, 1'b1, 3};
        vt[1]  = '{OP_SUB, 3'd7, 3'd1, 3'd2, 16'hFFFE, 1'b0, 1'b1, 3};
        vt[2]  = '{OP_SUB, 3'd7, 3'd1, 3'd1, 16'h0000, 1'b1, 1'b0, 3};
        vt[3]  = '{OP_SHL, 3'd0, 3'd4, 3'd0, 16'h0002, 1'b0, 1'b1, 3};
        vt[4]  = '{OP_SHR, 3'd5, 3'd4, 3'd0, 16'h4000, 1'b0, 1'b1, 3};
        vt[5]  = '{OP_XOR, 3'd0, 3'd3, 3'd3, 16'h0000, 1'b1, 1'b0, 3};
        vt[6]  = '{OP_MUL, 3'd6, 3'd1, 3'd2, 16'h000F, 1'b0, 1'b0, 18};
        vt[7]  = '{OP_MUL, 3'd7, 3'd3, 3'd3, 16'h0001, 1'b0, 1'b1, 18};
        vt[8]  = '{OP_AND, 3'd0, 3'd1, 3'd2, 16'h0001, 1'b0, 1'b0, 3};
        vt[9]  = '{OP_OR,  3'd0, 3'd1, 3'd2, 16'h0007, 1'b0, 1'b0, 3};
        vt[10] = '{OP_ADD, 3'd1, 3'd1, 3'd1, 16'h0006, 1'b0, 1'b0, 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_we", regInWE, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {flagZ, flagC}, 0);
        chk("rst_regIn", regIn, 0);
        chk("rst_addrs", {regInAddr, regOut1Addr, regOut2Addr}, 0);
        load = 1'b0;
        rst  = 1'b0;
        #1 chk("ready_after_rst", instrReady, 1);

        for (int i = 0; i < 11; i++) run_vec(vt[i]);

        // Valid held high across busy periods: four distinct destinations, r1 = 6.
        rds = '{3'd2, 3'd3, 3'd4, 3'd6};
        issued = 0; nw = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (regInWE) begin
                if (nw < 4) begin waddr[nw] = regInAddr; wdata[nw] = regIn; wcyc[nw] = cyc; end
                nw++;
            end
            if (issued < 4) begin
                instrValid = 1'b1; instrOp = OP_OR; instrRd = rds[issued];
                instrRs1 = 3'd1; instrRs2 = 3'd1;
                if (instrReady) issued++;
            end else begin
                instrValid = 1'b0;
            end
        end
        instrValid = 1'b0;
        chk("b2b_write_count", nw, 4);
        if (nw >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("b2b_addr", waddr[i], rds[i]);
                chk("b2b_data", wdata[i], 16'h0006);
                if (i > 0) chk("b2b_spacing", wcyc[i] - wcyc[i-1], 4);
            end
        end

        // Reset during the eighth MUL EXEC cycle must cancel the write to r5.
        @(negedge clk);
        instrValid = 1'b1; instrOp = OP_MUL; instrRd = 3'd5; instrRs1 = 3'd1; instrRs2 = 3'd1;
        n = 0;
        while (!instrReady && n < 50) begin @(negedge clk); n++; end
        chk("mul_rst_ready", instrReady, 1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            instrValid = 1'b0;
        end
        chk("mul_rst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_we_done", {regInWE, done}, 0);
        chk("async_rst_flags", {flagZ, flagC}, 0);
        chk("async_rst_regIn", regIn, 0);
        chk("async_rst_addrs", {regInAddr, regOut1Addr, regOut2Addr}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_first_cycle", instrReady, 1);
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (regInWE) extra++;
        end
        chk("no_write_after_abort", extra, 0);
        chk("r5_unchanged", rf[5], 16'h4000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
